// File: rtl/a5_burst_decipher.sv
// Receive-side A5/1 burst decipher: key/frame load, warm-up,
// optional keystream skip, then XOR of a serial ciphertext burst.
module a5_burst_decipher #(
  parameter int KEYLEN      = 64,
  parameter int FRAMENUMLEN = 22,
  parameter int CHUNKLEN    = 114,
  parameter int WARMUP      = 100,
  parameter int SKIP_FIRST  = 0
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [KEYLEN-1:0]      key,
  input  logic [FRAMENUMLEN-1:0] frame,
  input  logic                   in_valid,
  input  logic                   in_bit,
  output logic                   in_ready,
  output logic                   out_valid,
  output logic                   out_bit,
  output logic [CHUNKLEN-1:0]    burst,
  output logic                   done,
  output logic                   busy
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_KEYLOAD,
    ST_FRAMELOAD,
    ST_WARMUP,
    ST_SKIP,
    ST_RUN
  } state_t;

  localparam logic [6:0] KEY_LAST   = 7'(KEYLEN - 1);
  localparam logic [6:0] FRAME_LAST = 7'(FRAMENUMLEN - 1);
  localparam logic [6:0] WARM_LAST  = 7'(WARMUP - 1);
  localparam logic [6:0] CHUNK_LAST = 7'(CHUNKLEN - 1);

  state_t                   state;
  logic [6:0]               cnt;
  logic [KEYLEN-1:0]        key_sh;
  logic [FRAMENUMLEN-1:0]   frame_sh;
  logic [18:0]              r1, n1;
  logic [21:0]              r2, n2;
  logic [22:0]              r3, n3;
  logic                     maj, all_step, maj_step, ld;
  logic                     en1, en2, en3, ks;

  assign busy     = (state != ST_IDLE);
  assign in_ready = (state == ST_RUN);

  always_comb begin
    maj      = (r1[8] & r2[10]) | (r1[8] & r3[10]) | (r2[10] & r3[10]);
    all_step = (state == ST_KEYLOAD) || (state == ST_FRAMELOAD);
    maj_step = (state == ST_WARMUP) || (state == ST_SKIP) ||
               ((state == ST_RUN) && in_valid);
    ld = 1'b0;
    if (state == ST_KEYLOAD) ld = key_sh[0];
    else if (state == ST_FRAMELOAD) ld = frame_sh[0];
    en1 = all_step || (maj_step && (r1[8] == maj));
    en2 = all_step || (maj_step && (r2[10] == maj));
    en3 = all_step || (maj_step && (r3[10] == maj));
    n1 = en1 ? {r1[17:0], r1[18] ^ r1[17] ^ r1[16] ^ r1[13] ^ ld} : r1;
    n2 = en2 ? {r2[20:0], r2[21] ^ r2[20] ^ ld} : r2;
    n3 = en3 ? {r3[21:0], r3[22] ^ r3[21] ^ r3[20] ^ r3[7] ^ ld} : r3;
    // keystream comes from the post-step register state
    ks = n1[18] ^ n2[21] ^ n3[22];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      key_sh    <= '0;
      frame_sh  <= '0;
      r1        <= '0;
      r2        <= '0;
      r3        <= '0;
      out_valid <= 1'b0;
      out_bit   <= 1'b0;
      done      <= 1'b0;
      burst     <= '0;
    end else begin
      out_valid <= 1'b0;
      done      <= 1'b0;
      r1        <= n1;
      r2        <= n2;
      r3        <= n3;
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            key_sh   <= key;
            frame_sh <= frame;
            r1       <= '0;
            r2       <= '0;
            r3       <= '0;
            burst    <= '0;
            cnt      <= '0;
            state    <= ST_KEYLOAD;
          end
        end
        ST_KEYLOAD: begin
          key_sh <= key_sh >> 1;
          if (cnt == KEY_LAST) begin
            cnt   <= '0;
            state <= ST_FRAMELOAD;
          end else begin
            cnt <= cnt + 7'd1;
          end
        end
        ST_FRAMELOAD: begin
          frame_sh <= frame_sh >> 1;
          if (cnt == FRAME_LAST) begin
            cnt   <= '0;
            state <= ST_WARMUP;
          end else begin
            cnt <= cnt + 7'd1;
          end
        end
        ST_WARMUP: begin
          if (cnt == WARM_LAST) begin
            cnt   <= '0;
            state <= (SKIP_FIRST != 0) ? ST_SKIP : ST_RUN;
          end else begin
            cnt <= cnt + 7'd1;
          end
        end
        ST_SKIP: begin
          if (cnt == CHUNK_LAST) begin
            cnt   <= '0;
            state <= ST_RUN;
          end else begin
            cnt <= cnt + 7'd1;
          end
        end
        ST_RUN: begin
          if (in_valid) begin
            out_bit    <= in_bit ^ ks;
            out_valid  <= 1'b1;
            burst[cnt] <= in_bit ^ ks;
            if (cnt == CHUNK_LAST) begin
              cnt   <= '0;
              done  <= 1'b1;
              state <= ST_IDLE;
            end else begin
              cnt <= cnt + 7'd1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_a5_burst_decipher.sv
// Directed bench for a5_burst_decipher using the published
// A5/1 reference vector in both keystream-skip settings.
module tb_a5_burst_decipher;

  localparam int N = 114;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [63:0]   key   = 64'hEFCDAB8967452312;
  logic [21:0]   frame = 22'h134;

  logic          start0 = 0, in_valid0 = 0, in_bit0 = 0;
  logic          in_ready0, out_valid0, out_bit0, done0, busy0;
  logic [N-1:0]  burst0;

  logic          start1 = 0, in_valid1 = 0, in_bit1 = 0;
  logic          in_ready1, out_valid1, out_bit1, done1, busy1;
  logic [N-1:0]  burst1;

  logic [119:0]  ks0_hex = 120'h534EAA582FE8151AB6E1855A728C00;
  logic [119:0]  ks1_hex = 120'h24FD35A35D5FB6526D32F906DF1AC0;
  logic [N-1:0]  exp0, exp1;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  a5_burst_decipher #(.SKIP_FIRST(0)) dut0 (
    .clock(clock), .reset(reset), .start(start0),
    .key(key), .frame(frame),
    .in_valid(in_valid0), .in_bit(in_bit0),
    .in_ready(in_ready0), .out_valid(out_valid0),
    .out_bit(out_bit0), .burst(burst0),
    .done(done0), .busy(busy0)
  );

  a5_burst_decipher #(.SKIP_FIRST(1)) dut1 (
    .clock(clock), .reset(reset), .start(start1),
    .key(key), .frame(frame),
    .in_valid(in_valid1), .in_bit(in_bit1),
    .in_ready(in_ready1), .out_valid(out_valid1),
    .out_bit(out_bit1), .burst(burst1),
    .done(done1), .busy(busy1)
  );

  task automatic drive(input int sel, input logic st,
                       input logic iv, input logic ib);
    if (sel == 0) begin
      start0 = st; in_valid0 = iv; in_bit0 = ib;
    end else begin
      start1 = st; in_valid1 = iv; in_bit1 = ib;
    end
  endtask

  // Called at a negedge; start is driven in the current cycle (cycle 0).
  task automatic run(input int sel, input bit use_ks, input bit gaps,
                     input bit iv_early, input int stop_after,
                     input int extra_start,
                     output logic [N-1:0] bits, output int nout,
                     output int rdy_at, output int ov_at,
                     output bit bsy1, output bit done_ok,
                     output int done_n, output bit tmo);
    int cyc, acc;
    bit fin, ov, ob, rdy, dn, bs, iv;
    bits = '0; nout = 0; rdy_at = -1; ov_at = -1;
    done_ok = 0; done_n = -1; acc = 0; fin = 0;
    drive(sel, 1'b1, iv_early, 1'b0);
    @(negedge clock);
    cyc = 1;
    bsy1 = (sel == 0) ? busy0 : busy1;
    while (!fin && cyc < 2000) begin
      ov  = (sel == 0) ? out_valid0 : out_valid1;
      ob  = (sel == 0) ? out_bit0 : out_bit1;
      rdy = (sel == 0) ? in_ready0 : in_ready1;
      dn  = (sel == 0) ? done0 : done1;
      bs  = (sel == 0) ? busy0 : busy1;
      if (rdy && rdy_at < 0) rdy_at = cyc;
      if (ov) begin
        if (ov_at < 0) ov_at = cyc;
        if (nout < N) bits[nout] = ob;
        nout++;
      end
      if (dn) begin
        done_n  = nout;
        done_ok = !bs && !rdy && ov;
        fin     = 1;
      end
      if (stop_after > 0 && nout >= stop_after) fin = 1;
      if (!fin) begin
        iv = rdy ? (gaps ? ($urandom_range(0, 2) != 0) : 1'b1) : iv_early;
        drive(sel, cyc == extra_start, iv,
              (rdy && iv && use_ks && acc < N) ? exp0[acc] : 1'b0);
        if (rdy && iv) acc++;
        @(negedge clock);
        cyc++;
      end
    end
    tmo = !fin;
    drive(sel, 1'b0, 1'b0, 1'b0);
  endtask

  logic [N-1:0] bits;
  int nout, rdy_at, ov_at, done_n;
  bit bsy1, done_ok, tmo;

  task automatic test_reset;
    reset = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if ({out_valid0, out_bit0, done0, busy0, in_ready0} !== 5'b0) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=00000",
               {out_valid0, out_bit0, done0, busy0, in_ready0});
    end
    checks++;
    if (burst0 !== '0) begin
      failures++;
      $display("FAIL reset_burst got=%h exp=0", burst0);
    end
    checks++;
    if ({busy1, in_ready1, out_valid1} !== 3'b0) begin
      failures++;
      $display("FAIL reset_dut1 got=%b exp=000",
               {busy1, in_ready1, out_valid1});
    end
    reset = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_standard;
    run(0, 0, 0, 0, 0, -1, bits, nout, rdy_at, ov_at,
        bsy1, done_ok, done_n, tmo);
    checks++;
    if (tmo) begin
      failures++;
      $display("FAIL std_timeout got=1 exp=0");
    end
    checks++;
    if (bits !== exp0) begin
      failures++;
      $display("FAIL std_bits got=%h exp=%h", bits, exp0);
    end
    checks++;
    if (burst0 !== exp0) begin
      failures++;
      $display("FAIL std_burst got=%h exp=%h", burst0, exp0);
    end
    checks++;
    if (burst0[7:0] !== 8'hCA) begin
      failures++;
      $display("FAIL std_first8 got=%h exp=ca", burst0[7:0]);
    end
    checks++;
    if (nout !== 114 || done_n !== 114) begin
      failures++;
      $display("FAIL std_count got=%0d/%0d exp=114/114", nout, done_n);
    end
    checks++;
    if (!done_ok) begin
      failures++;
      $display("FAIL std_done_flags got=0 exp=1");
    end
    checks++;
    if (ov_at !== 188) begin
      failures++;
      $display("FAIL std_latency got=%0d exp=188", ov_at);
    end
  endtask

  task automatic test_skip_first;
    run(1, 0, 0, 0, 0, -1, bits, nout, rdy_at, ov_at,
        bsy1, done_ok, done_n, tmo);
    checks++;
    if (tmo || bits !== exp1) begin
      failures++;
      $display("FAIL skip_bits got=%h exp=%h tmo=%0d", bits, exp1, tmo);
    end
    checks++;
    if (burst1 !== exp1) begin
      failures++;
      $display("FAIL skip_burst got=%h exp=%h", burst1, exp1);
    end
    checks++;
    if (rdy_at !== 301) begin
      failures++;
      $display("FAIL skip_ready got=%0d exp=301", rdy_at);
    end
    checks++;
    if (nout !== 114 || !done_ok) begin
      failures++;
      $display("FAIL skip_done got=%0d/%0d exp=114/1", nout, done_ok);
    end
  endtask

  task automatic test_timing;
    run(0, 0, 0, 0, 0, 50, bits, nout, rdy_at, ov_at,
        bsy1, done_ok, done_n, tmo);
    checks++;
    if (bsy1 !== 1'b1) begin
      failures++;
      $display("FAIL tim_busy1 got=%0d exp=1", bsy1);
    end
    checks++;
    if (rdy_at !== 187) begin
      failures++;
      $display("FAIL tim_ready got=%0d exp=187", rdy_at);
    end
    checks++;
    if (tmo || bits !== exp0) begin
      failures++;
      $display("FAIL tim_start50 got=%h exp=%h", bits, exp0);
    end
  endtask

  task automatic test_gaps;
    run(0, 1, 1, 0, 0, -1, bits, nout, rdy_at, ov_at,
        bsy1, done_ok, done_n, tmo);
    checks++;
    if (tmo || bits !== '0) begin
      failures++;
      $display("FAIL gap_plain got=%h exp=0 tmo=%0d", bits, tmo);
    end
    checks++;
    if (burst0 !== '0) begin
      failures++;
      $display("FAIL gap_burst got=%h exp=0", burst0);
    end
    checks++;
    if (nout !== 114 || !done_ok) begin
      failures++;
      $display("FAIL gap_count got=%0d/%0d exp=114/1", nout, done_ok);
    end
  endtask

  task automatic test_reset_mid;
    bit seen_done;
    run(0, 0, 0, 0, 40, -1, bits, nout, rdy_at, ov_at,
        bsy1, done_ok, done_n, tmo);
    checks++;
    if (tmo || nout !== 40) begin
      failures++;
      $display("FAIL mid_partial got=%0d exp=40", nout);
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({out_valid0, out_bit0, done0, busy0, in_ready0} !== 5'b0
        || burst0 !== '0) begin
      failures++;
      $display("FAIL mid_reset got=%b/%h exp=00000/0",
               {out_valid0, out_bit0, done0, busy0, in_ready0}, burst0);
    end
    @(negedge clock);
    reset = 1'b1;
    seen_done = 0;
    repeat (3) begin
      @(negedge clock);
      if (done0 || busy0) seen_done = 1;
    end
    checks++;
    if (seen_done) begin
      failures++;
      $display("FAIL mid_idle got=1 exp=0");
    end
    run(0, 0, 0, 0, 0, -1, bits, nout, rdy_at, ov_at,
        bsy1, done_ok, done_n, tmo);
    checks++;
    if (tmo || bits !== exp0 || burst0 !== exp0) begin
      failures++;
      $display("FAIL mid_rerun got=%h exp=%h", bits, exp0);
    end
  endtask

  task automatic test_early_valid;
    run(0, 0, 0, 1, 0, -1, bits, nout, rdy_at, ov_at,
        bsy1, done_ok, done_n, tmo);
    checks++;
    if (ov_at !== 188) begin
      failures++;
      $display("FAIL early_ov got=%0d exp=188", ov_at);
    end
    checks++;
    if (bits[0] !== 1'b0 || bits !== exp0) begin
      failures++;
      $display("FAIL early_bits got=%h exp=%h", bits, exp0);
    end
  endtask

  task automatic test_back_to_back;
    run(0, 0, 0, 0, 0, -1, bits, nout, rdy_at, ov_at,
        bsy1, done_ok, done_n, tmo);
    run(0, 0, 0, 0, 0, -1, bits, nout, rdy_at, ov_at,
        bsy1, done_ok, done_n, tmo);
    checks++;
    if (bsy1 !== 1'b1) begin
      failures++;
      $display("FAIL b2b_start got=%0d exp=1", bsy1);
    end
    checks++;
    if (tmo || bits !== exp0 || rdy_at !== 187) begin
      failures++;
      $display("FAIL b2b_bits got=%h rdy=%0d exp=%h rdy=187",
               bits, rdy_at, exp0);
    end
  endtask

  initial begin
    for (int k = 0; k < N; k++) begin
      exp0[k] = ks0_hex[119-k];
      exp1[k] = ks1_hex[119-k];
    end
    test_reset;
    test_standard;
    test_skip_first;
    test_timing;
    test_gaps;
    test_reset_mid;
    test_early_valid;
    test_back_to_back;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/a5_burst_decipher.md
# a5_burst_decipher

Receive-side A5/1 burst decipher. Takes a 64-bit session key and a 22-bit frame number, runs the full A5/1 initialisation, then XORs an incoming serial ciphertext burst of 114 bits with the keystream. Plaintext is returned both as a serial stream and as a parallel 114-bit word. It is the counterpart of the transmit-side cipher stage: it performs its own key/frame loading and warm-up so the link end needs no external sequencing.

## Interface
- KEYLEN, 64, session key width
- FRAMENUMLEN, 22, frame number width
- CHUNKLEN, 114, bits per burst
- WARMUP, 100, discarded majority-clocked steps after loading
- SKIP_FIRST, 0, 0 = decipher with keystream bits 0..113 (downlink at MS); 1 = discard 114 bits first and use bits 114..227 (uplink at BTS)

- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low; all state cleared while low
- start  in  1  begin a burst; sampled only in IDLE
- key  in  KEYLEN  session key, bit i loaded at key-load step i (LSB first)
- frame  in  FRAMENUMLEN  frame number, bit i loaded at frame-load step i (LSB first)
- in_valid  in  1  ciphertext bit present
- in_bit  in  1  ciphertext bit
- in_ready  out  1  block accepts a ciphertext bit this cycle
- out_valid  out  1  one-cycle pulse, out_bit valid
- out_bit  out  1  deciphered bit
- burst  out  CHUNKLEN  deciphered word, burst[k] = k-th plaintext bit; held until next start
- done  out  1  one-cycle pulse with last out_valid
- busy  out  1  high in every state except IDLE

## Operation
- Registers: R1 19 b (taps 13,16,17,18; clock bit 8), R2 22 b (taps 20,21; clock bit 10), R3 23 b (taps 7,20,21,22; clock bit 10). A step shifts left: r <= {r[LEN-2:0], fb}, fb = XOR of taps.
- Keystream bit = R1[18] ^ R2[21] ^ R3[22], taken from the post-step state.
- Majority step: maj = majority of the three clock bits; only registers whose clock bit equals maj step.
- FSM states: IDLE, KEYLOAD, FRAMELOAD, WARMUP, SKIP, RUN.
- IDLE: registers hold. On start, capture key/frame, zero R1–R3, zero burst, and go to KEYLOAD.
- KEYLOAD: 64 cycles. All three registers step every cycle, with fb ^= key[i].
- FRAMELOAD: 22 cycles, same as KEYLOAD using frame[i].
- WARMUP: WARMUP cycles of majority steps; output discarded.
- SKIP: entered only if SKIP_FIRST=1. CHUNKLEN cycles of majority steps; output discarded.
- RUN:
  - in_ready=1.
  - On in_valid & in_ready: one majority step; next cycle out_bit = in_bit ^ keystream, out_valid=1, burst[k] = same bit, k++.
  - With no handshake, registers hold.
  - After the CHUNKLEN-th acceptance, return to IDLE.
- Counters: 7-bit step/bit counter, reloaded on each state entry. No wrap beyond CHUNKLEN-1.

## Timing
- Reset values: in_ready=0, out_valid=0, out_bit=0, done=0, busy=0, burst=0, R1–R3=0, state IDLE.
- Start sampled at cycle 0. KEYLOAD runs cycles 1–64, FRAMELOAD 65–86, WARMUP 87–186.
- in_ready first high at cycle 187 (SKIP_FIRST=0) or 301 (SKIP_FIRST=1).
- Latency: accepted bit -> out_valid exactly 1 cycle. Back-to-back acceptance gives one output per cycle.
- done is high in the same cycle as the 114th out_valid; busy and in_ready are already low in that cycle.
- in_valid outside RUN is ignored; no bit is consumed.
- start while busy is ignored. start in the same cycle as the final out_valid/done is accepted (state is IDLE).
- reset low mid-burst: immediate return to reset values. The partial burst is discarded, and no done is issued.

## Test plan
- Standard vector: key=64'hEFCDAB8967452312, frame=22'h134, SKIP_FIRST=0, 114 zero ciphertext bits -> plaintext equals keystream 534EAA582FE8151AB6E1855A728C00 (MSB-first bytes). burst[0..7]=0,1,0,1,0,0,1,1; done at 114th output.
- Same key/frame, SKIP_FIRST=1 -> keystream 24FD35A35D5FB6526D32F906DF1AC0; in_ready first high at cycle 301.
- Same vector with ciphertext = keystream fed with random in_valid gaps -> all 114 plaintext bits 0. Registers do not advance during gaps; out_valid count = 114.
- Timing check: start at cycle 0 -> busy at cycle 1, in_ready rises at exactly cycle 187. A start pulse at cycle 50 has no effect.
- Reset asserted after 40 accepted bits -> all outputs 0, state IDLE. A fresh start then reproduces the standard vector exactly.
- in_valid held high during load/warm-up -> no out_valid before cycle 188; first plaintext bit still 0 for the zero-ciphertext vector.
